// File: rtl/apb_slave_mem.sv
// APB completer serving a word-addressed register memory with a fixed number of
// wait states; misaligned or out-of-range accesses complete with pslver set.
module apb_slave_mem #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] paddr,
    input  logic        pselx,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslver
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic          pready_d, pslver_d;
    logic [31:0]   prdata_d;
    logic          load_rsp;
    logic          mem_we;
    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] setup_idx;
    logic          setup_err;

    // Upper address bits must be zero: no aliasing onto the decoded words.
    assign setup_idx = paddr[AW+1:2];
    assign setup_err = (paddr[1:0] != 2'b00) || (paddr[31:AW+2] != '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        write_d  = write_q;
        err_d    = err_q;
        pready_d = pready;
        pslver_d = pslver;
        prdata_d = prdata;
        load_rsp = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pselx && !penable) begin
                    idx_d   = setup_idx;
                    write_d = pwrite;
                    err_d   = setup_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d  = S_DONE;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (!pselx) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    pready_d = 1'b0;
                    pslver_d = 1'b0;
                end else if (penable) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d  = S_DONE;
                        load_rsp = 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!pselx) begin
                    state_d  = S_IDLE;
                    pready_d = 1'b0;
                    pslver_d = 1'b0;
                end else if (penable) begin
                    state_d  = S_IDLE;
                    pready_d = 1'b0;
                    pslver_d = 1'b0;
                    mem_we   = write_q && !err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Response uses the just-latched request when completing straight from SETUP.
        if (load_rsp) begin
            pready_d = 1'b1;
            pslver_d = err_d;
            prdata_d = (write_d || err_d) ? '0 : mem[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            pready  <= 1'b0;
            pslver  <= 1'b0;
            prdata  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            err_q   <= err_d;
            pready  <= pready_d;
            pslver  <= pslver_d;
            prdata  <= prdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (mem_we) begin
            mem[idx_q] <= pwdata;
        end
    end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: three instances cover WAIT_CYCLES = 0, 1 and 3
// (index 0, 1, 2 of the bus arrays).
module tb_apb_slave_mem;

    logic        clk;
    logic        rst_n;
    logic [31:0] paddr  [3];
    logic [31:0] pwdata [3];
    logic [31:0] prdata [3];
    logic        psel   [3];
    logic        pen    [3];
    logic        pwr    [3];
    logic        prdy   [3];
    logic        pslv   [3];

    int total = 0;
    int bad   = 0;

    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst_n), .paddr(paddr[0]), .pselx(psel[0]), .penable(pen[0]),
        .pwrite(pwr[0]), .pwdata(pwdata[0]), .pready(prdy[0]), .prdata(prdata[0]), .pslver(pslv[0]));
    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst_n), .paddr(paddr[1]), .pselx(psel[1]), .penable(pen[1]),
        .pwrite(pwr[1]), .pwdata(pwdata[1]), .pready(prdy[1]), .prdata(prdata[1]), .pslver(pslv[1]));
    apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst_n), .paddr(paddr[2]), .pselx(psel[2]), .penable(pen[2]),
        .pwrite(pwr[2]), .pwdata(pwdata[2]), .pready(prdy[2]), .prdata(prdata[2]), .pslver(pslv[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle(input int d);
        psel[d] = 1'b0;
        pen[d]  = 1'b0;
    endtask

    // One transfer starting at a negedge; returns at the negedge after the completing edge
    // with the bus left in ACCESS (ignored by an idle slave) to allow back-to-back SETUP.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] wd_late,
                        output logic [31:0] rd, output logic err, output int waits,
                        output logic post_rdy);
        int n;
        waits = 0;
        n     = 0;
        psel[d] = 1'b1; pen[d] = 1'b0; paddr[d] = addr; pwr[d] = wr; pwdata[d] = wd;
        cyc();
        pen[d] = 1'b1; paddr[d] = ~addr; pwr[d] = ~wr;
        while (prdy[d] !== 1'b1 && n < 40) begin
            waits++;
            if (waits >= 2) pwdata[d] = wd_late;
            cyc();
            n++;
        end
        if (n >= 40) begin
            bad++;
            $display("FAIL xfer_timeout dut=%0d addr=%h pready=%b required=1", d, addr, prdy[d]);
        end
        total++;
        rd  = prdata[d];
        err = pslv[d];
        cyc();
        post_rdy = prdy[d];
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            if (prdy[i] !== 1'b0) begin bad++; $display("FAIL rst_pready dut=%0d got=%b exp=0", i, prdy[i]); end
            total++;
            if (prdata[i] !== 32'h0) begin bad++; $display("FAIL rst_prdata dut=%0d got=%h exp=0", i, prdata[i]); end
            total++;
            if (pslv[i] !== 1'b0) begin bad++; $display("FAIL rst_pslver dut=%0d got=%b exp=0", i, pslv[i]); end
            total++;
        end
    endtask

    task automatic test_wait1();
        logic [31:0] rd; logic err, post; int w;
        xfer(1, 1'b1, 32'h08, 32'hDEADBEEF, 32'hDEADBEEF, rd, err, w, post);
        if (w !== 1) begin bad++; $display("FAIL w1_wr_waits got=%0d exp=1", w); end
        total++;
        if (err !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL w1_wr_rsp got=%b/%h exp=0/0", err, rd); end
        total++;
        if (post !== 1'b0) begin bad++; $display("FAIL w1_wr_post_pready got=%b exp=0", post); end
        total++;
        xfer(1, 1'b0, 32'h08, 32'h0, 32'h0, rd, err, w, post);
        if (w !== 1) begin bad++; $display("FAIL w1_rd_waits got=%0d exp=1", w); end
        total++;
        if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL w1_rd_data got=%h exp=deadbeef", rd); end
        total++;
        if (err !== 1'b0) begin bad++; $display("FAIL w1_rd_pslver got=%b exp=0", err); end
        total++;
        bus_idle(1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] data  [3];
        logic [31:0] rd; logic err, post; int w;
        addrs[0] = 32'h00; addrs[1] = 32'h04; addrs[2] = 32'h3C;
        data[0] = 32'hA0A00001; data[1] = 32'hB0B00002; data[2] = 32'hC0C00003;
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, addrs[i], data[i], data[i], rd, err, w, post);
            if (w !== 0 || err !== 1'b0 || post !== 1'b0) begin
                bad++; $display("FAIL b2b_wr_%0d waits/err/post got=%0d/%b/%b exp=0/0/0", i, w, err, post);
            end
            total++;
        end
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b0, addrs[i], 32'h0, 32'h0, rd, err, w, post);
            if (rd !== data[i] || err !== 1'b0) begin
                bad++; $display("FAIL b2b_rd_%0d got=%h/%b exp=%h/0", i, rd, err, data[i]);
            end
            total++;
            if (w !== 0) begin bad++; $display("FAIL b2b_rd_waits_%0d got=%0d exp=0", i, w); end
            total++;
        end
        bus_idle(0);
    endtask

    task automatic test_errors();
        logic [31:0] bad_addr [3];
        logic [31:0] rd; logic err, post; int w;
        bad_addr[0] = 32'h40; bad_addr[1] = 32'h06; bad_addr[2] = 32'h10000000;
        for (int i = 0; i < 3; i++) begin
            xfer(0, 1'b1, bad_addr[i], 32'h12345678, 32'h12345678, rd, err, w, post);
            if (err !== 1'b1) begin bad++; $display("FAIL err_wr_%0d pslver got=%b exp=1", i, err); end
            total++;
        end
        xfer(0, 1'b0, 32'h00, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'hA0A00001 || err !== 1'b0) begin bad++; $display("FAIL err_word0 got=%h/%b exp=a0a00001/0", rd, err); end
        total++;
        xfer(0, 1'b0, 32'h04, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'hB0B00002 || err !== 1'b0) begin bad++; $display("FAIL err_word1 got=%h/%b exp=b0b00002/0", rd, err); end
        total++;
        xfer(0, 1'b0, 32'h40, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h0 || err !== 1'b1) begin bad++; $display("FAIL err_rd got=%h/%b exp=0/1", rd, err); end
        total++;
        bus_idle(0);
    endtask

    task automatic test_idle_penable();
        logic [31:0] rd; logic err, post; int w;
        logic seen;
        seen = 1'b0;
        psel[0] = 1'b1; pen[0] = 1'b1; paddr[0] = 32'h3C; pwr[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (prdy[0] !== 1'b0) seen = 1'b1;
        end
        if (seen !== 1'b0) begin bad++; $display("FAIL idle_penable pready got=1 exp=0"); end
        total++;
        bus_idle(0);
        cyc();
        xfer(0, 1'b0, 32'h3C, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'hC0C00003) begin bad++; $display("FAIL idle_penable_rd got=%h exp=c0c00003", rd); end
        total++;
        bus_idle(0);
    endtask

    task automatic test_late_wdata();
        logic [31:0] rd; logic err, post; int w;
        xfer(2, 1'b1, 32'h10, 32'h1, 32'h2, rd, err, w, post);
        if (w !== 3) begin bad++; $display("FAIL late_wr_waits got=%0d exp=3", w); end
        total++;
        xfer(2, 1'b0, 32'h10, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h2) begin bad++; $display("FAIL late_wdata got=%h exp=00000002", rd); end
        total++;
        bus_idle(2);
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err, post; int w;
        logic seen;
        xfer(2, 1'b1, 32'h0C, 32'hAAAA5555, 32'hAAAA5555, rd, err, w, post);
        bus_idle(2);
        cyc();
        psel[2] = 1'b1; pen[2] = 1'b0; paddr[2] = 32'h0C; pwr[2] = 1'b1; pwdata[2] = 32'h11111111;
        cyc();
        pen[2] = 1'b1;
        cyc();
        bus_idle(2);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (prdy[2] !== 1'b0) seen = 1'b1;
        end
        if (seen !== 1'b0) begin bad++; $display("FAIL abort_pready got=1 exp=0"); end
        total++;
        xfer(2, 1'b0, 32'h0C, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'hAAAA5555 || err !== 1'b0) begin bad++; $display("FAIL abort_rd got=%h/%b exp=aaaa5555/0", rd, err); end
        total++;
        bus_idle(2);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err, post; int w;
        cyc();
        psel[2] = 1'b1; pen[2] = 1'b0; paddr[2] = 32'h08; pwr[2] = 1'b1; pwdata[2] = 32'h5A5A5A5A;
        cyc();
        pen[2] = 1'b1;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        if (prdy[2] !== 1'b0 || prdata[2] !== 32'h0 || pslv[2] !== 1'b0) begin
            bad++; $display("FAIL rstmid_w3 got=%b/%h/%b exp=0/0/0", prdy[2], prdata[2], pslv[2]);
        end
        total++;
        if (prdata[1] !== 32'h0) begin bad++; $display("FAIL rstmid_w1_prdata got=%h exp=0", prdata[1]); end
        total++;
        for (int i = 0; i < 3; i++) bus_idle(i);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        xfer(1, 1'b0, 32'h08, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_w1_mem got=%h exp=0", rd); end
        total++;
        bus_idle(1);
        xfer(0, 1'b0, 32'h3C, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_w0_mem got=%h exp=0", rd); end
        total++;
        bus_idle(0);
        xfer(2, 1'b0, 32'h0C, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_w3_mem0c got=%h exp=0", rd); end
        total++;
        xfer(2, 1'b0, 32'h10, 32'h0, 32'h0, rd, err, w, post);
        if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_w3_mem10 got=%h exp=0", rd); end
        total++;
        bus_idle(2);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            psel[i] = 1'b0; pen[i] = 1'b0; pwr[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        cyc();
        test_wait1();
        test_back_to_back();
        test_errors();
        test_idle_penable();
        test_late_wdata();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
